// File: rtl/fetch_stage_if.sv
// Bundle of instruction-memory, hazard-control and decode-packet signals
// between the fetch stage and the rest of the pipeline.
interface fetch_stage_if;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       stall_F;
  logic       flush_D;
  logic       pc_load;
  logic [7:0] pc_target;
  logic [7:0] instr_D;
  logic [7:0] imm_D;
  logic [7:0] pc_reg_D;
  logic [7:0] pc_plus_1_D;
  logic       valid_D;

  modport master (
    output imem_addr, instr_D, imm_D, pc_reg_D, pc_plus_1_D, valid_D,
    input  imem_rdata, stall_F, flush_D, pc_load, pc_target
  );

  modport slave (
    input  imem_addr, instr_D, imm_D, pc_reg_D, pc_plus_1_D, valid_D,
    output imem_rdata, stall_F, flush_D, pc_load, pc_target
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register: owns the PC, assembles one- and
// two-byte instructions into a single decode packet.
module fetch_stage #(
  parameter logic [3:0] TWO_BYTE_OP    = 4'd12,
  parameter logic [7:0] RESET_VEC_ADDR = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, IMM = 2'd2} state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc_reg;
    logic [7:0] pc_plus_1;
  } packet_t;

  state_t     state_reg, state_next;
  logic [7:0] pc_reg, pc_next;
  logic [7:0] op_lat_reg, op_lat_next;
  logic [7:0] op_pc_reg, op_pc_next;
  packet_t    pkt_reg, pkt_next, pkt_adv;
  logic [7:0] pc_inc;
  logic       is_two_byte;

  assign pc_inc      = pc_reg + 8'd1;
  assign is_two_byte = (bus.imem_rdata[7:4] == TWO_BYTE_OP);
  assign bus.imem_addr = (state_reg == BOOT) ? RESET_VEC_ADDR : pc_reg;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    op_lat_next = op_lat_reg;
    op_pc_next  = op_pc_reg;
    pkt_next    = pkt_reg;
    pkt_adv     = '0;

    case (state_reg)
      BOOT: begin
        pc_next    = bus.imem_rdata;
        state_next = FETCH;
        pkt_next   = '0;
      end
      FETCH, IMM: begin
        // Packet a normal advance would write; an opcode-only fetch is a bubble
        if (state_reg == IMM)
          pkt_adv = '{valid: 1'b1, instr: op_lat_reg, imm: bus.imem_rdata,
                      pc_reg: op_pc_reg, pc_plus_1: pc_inc};
        else if (!is_two_byte)
          pkt_adv = '{valid: 1'b1, instr: bus.imem_rdata, imm: 8'h00,
                      pc_reg: pc_reg, pc_plus_1: pc_inc};

        if (bus.pc_load) begin
          pc_next     = bus.pc_target;
          state_next  = FETCH;
          op_lat_next = 8'h00;
        end else if (!bus.stall_F) begin
          pc_next = pc_inc;
          if (state_reg == IMM) begin
            state_next = FETCH;
          end else if (is_two_byte) begin
            op_lat_next = bus.imem_rdata;
            op_pc_next  = pc_reg;
            state_next  = IMM;
          end
        end

        if (bus.flush_D)
          pkt_next = '0;
        else if (!bus.stall_F)
          pkt_next = pkt_adv;
      end
      default: begin
        state_next = BOOT;
        pkt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= BOOT;
      pc_reg     <= 8'h00;
      op_lat_reg <= 8'h00;
      op_pc_reg  <= 8'h00;
      pkt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      op_lat_reg <= op_lat_next;
      op_pc_reg  <= op_pc_next;
      pkt_reg    <= pkt_next;
    end
  end

  assign bus.valid_D     = pkt_reg.valid;
  assign bus.instr_D     = pkt_reg.instr;
  assign bus.imm_D       = pkt_reg.imm;
  assign bus.pc_reg_D    = pkt_reg.pc_reg;
  assign bus.pc_plus_1_D = pkt_reg.pc_plus_1;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register for the 8-bit pipelined processor. It owns the PC and reads the byte-wide instruction memory. It assembles one- and two-byte instructions into a single decode-stage packet (instr, imm, pc_reg, pc_plus_1) that the decoder and the ID/EX register consume. It honours stall and flush from the hazard unit and PC redirects from branch/ret logic.

## Interface
Parameters:
- TWO_BYTE_OP, 4'd12, opcode value in instr[7:4] that marks a two-byte instruction (immediate follows in the next byte)
- RESET_VEC_ADDR, 8'h00, imem address holding the start PC

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_addr  output  8  instruction memory address (combinational from PC / state)
- imem_rdata  input  8  instruction memory read data, combinational (same-cycle) read of imem_addr
- stall_F  input  1  hazard unit: hold PC, FSM and IF/ID contents
- flush_D  input  1  hazard unit: squash the IF/ID packet written this edge (bubble)
- pc_load  input  1  redirect PC (taken branch, call, ret, interrupt)
- pc_target  input  8  redirect address
- instr_D  output  8  opcode byte of the instruction in decode
- imm_D  output  8  immediate byte (0 for one-byte instructions)
- pc_reg_D  output  8  address of the opcode byte
- pc_plus_1_D  output  8  address of the byte after the complete instruction
- valid_D  output  1  packet in decode is a real instruction

## Operation
- State register: BOOT, FETCH, IMM. Internal: pc[7:0], op_lat[7:0] (held opcode), op_pc[7:0] (opcode address).
- imem_addr = RESET_VEC_ADDR in BOOT, else pc.
- BOOT: pc <= imem_rdata, state <= FETCH, packet invalid. Not affected by stall_F. flush_D and pc_load are ignored in BOOT.
- FETCH, no stall, no redirect, byte b = imem_rdata:
  - If b[7:4] == TWO_BYTE_OP: op_lat <= b, op_pc <= pc, pc <= pc+1, state <= IMM. The IF/ID packet becomes a bubble (valid_D=0, instr_D=0, imm_D=0, pc fields 0).
  - Otherwise: instr_D <= b, imm_D <= 0, pc_reg_D <= pc, pc_plus_1_D <= pc+1, valid_D <= 1, pc <= pc+1.
- IMM, no stall, no redirect: instr_D <= op_lat, imm_D <= imem_rdata, pc_reg_D <= op_pc, pc_plus_1_D <= pc+1, valid_D <= 1, pc <= pc+1, state <= FETCH.
- stall_F (no redirect): pc, state, op_lat, op_pc and all *_D outputs hold.
- pc_load (FETCH or IMM): pc <= pc_target, state <= FETCH, and op_lat is discarded. pc_load wins over stall_F.
- flush_D: the *_D outputs are written to the bubble values (all zero) this edge. flush_D wins over stall_F and over a normal packet write. It does not change pc or state unless pc_load is also high.
- Priority: reset > pc_load (PC/FSM) and flush_D (IF/ID) > stall_F > normal advance.
- Arithmetic: all PC sums are 8-bit modulo 256, so 8'hFF+1 = 8'h00. A two-byte instruction whose opcode is at 8'hFF takes its immediate from 8'h00.

## Timing
- Reset (reset high at a rising edge): state=BOOT, pc=0, op_lat=0, op_pc=0, and instr_D, imm_D, pc_reg_D, pc_plus_1_D, valid_D all 0. imem_addr=RESET_VEC_ADDR while in BOOT.
- First edge after reset release: BOOT -> FETCH. The second edge latches the first packet, so valid_D first rises 2 cycles after reset deasserts.
- One-byte instruction: 1 cycle fetch, one packet per cycle.
- Two-byte instruction: 2 cycles, with exactly one bubble packet followed by the assembled packet.
- Redirect: the new PC is used for fetch in the cycle after pc_load. The hazard unit asserts flush_D with pc_load to kill the wrong-path packet.
- Reset asserted mid-operation (including in IMM or during stall) returns to BOOT next edge. Any held opcode is lost.

## Test plan
- Boot: imem[0]=8'h10, imem[8'h10]=one-byte op 8'h14, release reset -> cycle 1 imem_addr=0x00; cycle 2 packet instr_D=8'h14, pc_reg_D=8'h10, pc_plus_1_D=8'h11, valid_D=1.
- Two-byte op: imem[0x20]=8'hC1, imem[0x21]=8'h5A -> one bubble (valid_D=0), then instr_D=8'hC1, imm_D=8'h5A, pc_reg_D=0x20, pc_plus_1_D=0x22. Next fetch is from 0x22.
- Stall: assert stall_F for 3 cycles while in IMM -> *_D, pc and state frozen. Release -> assembled packet appears on the next edge with the correct imm.
- Redirect in IMM: pc_load=1, pc_target=0x40, flush_D=1 -> valid_D=0 and the opcode is discarded. The next packet is from 0x40 with pc_reg_D=0x40. Repeat with stall_F also high: the redirect still takes effect.
- Wrap: two-byte opcode at 0xFF, imm at 0x00 -> pc_reg_D=0xFF, imm_D=imem[0x00], pc_plus_1_D=0x01.
- Synchronous reset mid-IMM -> all outputs 0 next edge, state BOOT, and the start PC is reloaded from imem[0].
